video_wr_packer: RTL and testbench
==================================

# video_wr_packer

Write-side width packer for the frame-buffer path. It accepts 32-bit pixel words from the video input pipeline and packs eight of them into each 256-bit beat. Beats are held in a small internal buffer, and the block issues fixed-length write bursts toward the DDR AXI write master. It is the counterpart of the 256-to-32 read FIFO on the display side. A frame-end flush pads the last partial beat and drains the remainder as a short burst.

## Interface
Parameters:
- BUF_DEPTH_WIDTH, 5, log2 of buffer depth in 256-bit beats (depth 32)
- BURST_LEN, 16, beats per full burst; 1..2^BUF_DEPTH_WIDTH

Ports (widths of in_data and wdata are fixed):
- clk  in  1  single clock for all logic
- rst  in  1  reset, asynchronous, active-high
- in_data  in  32  pixel word
- in_valid  in  1  in_data valid
- in_ready  out  1  word accepted when in_valid && in_ready
- frame_end  in  1  single-cycle flush request
- burst_req  out  1  burst request, held until acknowledged
- burst_len  out  $clog2(BURST_LEN)+1  beats in the requested burst
- burst_ack  in  1  request accepted when burst_req && burst_ack
- wdata  out  256  write beat
- wvalid  out  1  beat valid
- wready  in  1  beat accepted when wvalid && wready
- wlast  out  1  final beat of the burst
- water_level  out  BUF_DEPTH_WIDTH+1  buffered beat count; present only with the macro (see Configuration)

## Operation
- **Packing**
  - word_cnt runs 0..7.
  - Word k of a beat goes to wdata[32k+31:32k]; the first word sits in the LSBs.
  - An accepted word with word_cnt==7 commits the beat to the buffer and wraps word_cnt to 0.
- **Buffer**
  - Circular buffer with first-word-fall-through: wdata shows the head beat whenever the buffer is non-empty.
  - level = push count − pop count. Simultaneous push and pop leaves level unchanged.
- **in_ready** is deasserted in two cases:
  - word_cnt==7 and level==2^BUF_DEPTH_WIDTH;
  - the flush-commit cycle.
- **Flush**
  - On frame_end with word_cnt≠0, the partial beat is zero-padded and committed on the next cycle. in_ready is low for that cycle, and word_cnt is cleared.
  - frame_end also sets flush_flag.
  - frame_end arriving in the same cycle as an accepted word packs the word first. If that word completes the beat, no padded beat is produced.
  - frame_end while flush_flag is already set is merged, not counted twice.
- **FSM**
  - IDLE:
    - level≥BURST_LEN → REQ with burst_len=BURST_LEN.
    - Else flush_flag && level>0 && no commit pending → REQ with burst_len=level.
    - Else flush_flag && level==0 && word_cnt==0 → clear flush_flag.
  - REQ: burst_req=1 and burst_len is stable. req&&ack → DATA, remaining=burst_len.
  - DATA: wvalid=1 (buffer is guaranteed non-empty). Each handshake pops one beat and decrements remaining. wlast=(remaining==1). The handshake with wlast → IDLE.
- Input continues to be accepted in every state.

## Timing
- Reset values:
  - in_ready=1, burst_req=0, burst_len=0, wvalid=0, wlast=0, water_level=0.
  - word_cnt=0, flush_flag=0, FSM=IDLE.
  - wdata is don't-care while wvalid=0.
- Latency:
  - A beat committed at edge N appears in level from cycle N+1.
  - burst_req rises at the earliest one cycle after the threshold is met (registered FSM).
  - wvalid rises the cycle after burst_ack.
- burst_req and burst_len are held unchanged until acknowledged. wdata and wlast are held stable while wvalid && !wready.
- Asserting rst mid-burst clears all state. Buffered beats and the partial beat are discarded, and wlast is not issued.

## Configuration
- WR_PACKER_WATER_LEVEL_EN defined: the water_level port and its registered level output exist; water_level updates one cycle after a push or pop.
- Not defined: the port is absent. Level is still tracked internally for the FSM.

## Test plan
- **Full burst**
  - Stimulus: words 0..127 continuous; burst_ack=1 on first request; wready=1.
  - Required: one burst with burst_len=16. Beat0=0x00000007_…_00000000 (words 7..0). wlast only on beat 15, which holds words 127..120.
- **Flush**
  - Stimulus: words 0..19, then a frame_end pulse.
  - Required: burst_len=3. Beat2[127:0] holds words 19..16 and beat2[255:128]=0. flush_flag clears afterwards.
- **Coincident end**
  - Stimulus: frame_end in the same cycle as word 15 is accepted.
  - Required: burst_len=2, no padded beat.
- **Buffer full**
  - Stimulus: BUF_DEPTH_WIDTH=5, burst_ack held 0, 300 words offered.
  - Required: 263 words accepted. in_ready low while word 263 is presented. Once ack is given and a beat pops, the next acceptance occurs.
- **wready stalls**
  - Stimulus: wready toggled 1/0 per cycle.
  - Required: 16 beats delivered in order, wdata stable during stalls, exactly one wlast.
- **Reset mid-burst**
  - Stimulus: rst asserted after 5 beats of a burst.
  - Required: wvalid=0 and burst_req=0 immediately, level=0, no wlast. The first full burst after reset starts with word 0 of the new stream.

Source files
------------

// File: rtl/video_wr_packer.sv
// ============================================================================
// video_wr_packer
//
// Write-side width packer for the frame-buffer path. Packs eight 32-bit pixel
// words into each 256-bit beat (first word in the LSBs). Completed beats go
// into a circular buffer with first-word-fall-through, and fixed-length write
// bursts are requested toward the DDR AXI write master. A frame_end pulse
// zero-pads the last partial beat and drains whatever is buffered as a short
// burst.
//
// Optional feature macro: WR_PACKER_WATER_LEVEL_EN
//   defined     -> water_level output exists (registered buffered-beat count)
//   not defined -> no water_level port; level is still tracked internally
//
// Parameters:
//   BUF_DEPTH_WIDTH  log2 of buffer depth in 256-bit beats
//   BURST_LEN        beats per full burst (1 .. 2**BUF_DEPTH_WIDTH)
//
// Ports:
//   clk, rst       single clock, asynchronous active-high reset
//   in_data/valid  32-bit pixel word input, accepted when in_valid && in_ready
//   in_ready       low when the buffer cannot take a completed beat, or during
//                  the flush-commit cycle
//   frame_end      single-cycle flush request
//   burst_req/len  burst request and its beat count, held until burst_ack
//   burst_ack      request accepted when burst_req && burst_ack
//   wdata/wvalid   256-bit write beat, accepted when wvalid && wready
//   wlast          final beat of the current burst
//   water_level    buffered beat count (only with WR_PACKER_WATER_LEVEL_EN)
// ============================================================================
module video_wr_packer #(
    parameter int BUF_DEPTH_WIDTH = 5,
    parameter int BURST_LEN       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [31:0]                  in_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         frame_end,
    output logic                         burst_req,
    output logic [$clog2(BURST_LEN):0]   burst_len,
    input  logic                         burst_ack,
    output logic [255:0]                 wdata,
    output logic                         wvalid,
    input  logic                         wready,
    output logic                         wlast
`ifdef WR_PACKER_WATER_LEVEL_EN
    ,
    output logic [BUF_DEPTH_WIDTH:0]     water_level
`endif
);

    localparam int DEPTH = 1 << BUF_DEPTH_WIDTH;
    localparam int LEN_W = $clog2(BURST_LEN) + 1;
    localparam int LVL_W = BUF_DEPTH_WIDTH + 1;

    localparam logic [LVL_W-1:0] FULL_LEVEL  = LVL_W'(DEPTH);
    localparam logic [LVL_W-1:0] BURST_LEVEL = LVL_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] FULL_BURST  = LEN_W'(BURST_LEN);
    localparam logic [LEN_W-1:0] LEN_ONE     = LEN_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DATA
    } state_t;

    // Packing state
    logic [2:0]                 r_wordCnt;
    logic [255:0]               r_pack;
    logic                       r_commitPending;
    logic                       r_flushFlag;

    // Beat buffer
    logic [255:0]               r_mem [DEPTH];
    logic [BUF_DEPTH_WIDTH-1:0] r_wrPtr;
    logic [BUF_DEPTH_WIDTH-1:0] r_rdPtr;
    logic [LVL_W-1:0]           r_level;

    // Burst FSM
    state_t                     r_state;
    state_t                     w_stateNext;
    logic [LEN_W-1:0]           r_burstLen;
    logic [LEN_W-1:0]           w_burstLenNext;
    logic [LEN_W-1:0]           r_remaining;
    logic [LEN_W-1:0]           w_remainingNext;
    logic                       w_clearFlush;

    // Datapath strobes
    logic                       w_full;
    logic                       w_accept;
    logic                       w_wordCommit;
    logic                       w_flushCommit;
    logic                       w_push;
    logic                       w_pop;
    logic [255:0]               w_packNext;
    logic [255:0]               w_beatIn;

    assign w_full   = (r_level == FULL_LEVEL);

    // A word that would complete a beat is refused while the buffer is full,
    // so a normal commit never overflows. The flush-commit cycle also blocks
    // input so the padded beat is written before the next frame's words.
    assign in_ready = !r_commitPending && !((r_wordCnt == 3'd7) && w_full);

    assign w_accept      = in_valid && in_ready;
    assign w_wordCommit  = w_accept && (r_wordCnt == 3'd7);
    // A padded beat waits for room if the buffer happens to be full.
    assign w_flushCommit = r_commitPending && !w_full;
    assign w_push        = w_wordCommit || w_flushCommit;
    assign w_pop         = wvalid && wready;

    // Merge the incoming word into its lane of the partial beat.
    always_comb begin
        w_packNext = r_pack;
        if (w_accept) begin
            w_packNext[{r_wordCnt, 5'd0} +: 32] = in_data;
        end
    end

    // A flush commit writes r_pack as it stands: unused lanes are still zero
    // because r_pack is cleared on every commit.
    assign w_beatIn = w_wordCommit ? w_packNext : r_pack;

    // Packing counter, partial beat and flush bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wordCnt       <= 3'd0;
            r_pack          <= '0;
            r_commitPending <= 1'b0;
            r_flushFlag     <= 1'b0;
        end else begin
            if (w_push) begin
                r_pack    <= '0;
                r_wordCnt <= 3'd0;
            end else if (w_accept) begin
                r_pack    <= w_packNext;
                r_wordCnt <= r_wordCnt + 3'd1;
            end

            // The coincident word is packed first; only a beat left partial
            // after it needs a padded commit.
            if (w_flushCommit) begin
                r_commitPending <= 1'b0;
            end else if (frame_end && !r_commitPending) begin
                if (w_accept) begin
                    r_commitPending <= (r_wordCnt != 3'd7);
                end else begin
                    r_commitPending <= (r_wordCnt != 3'd0);
                end
            end

            // A repeated frame_end while the flag is set simply re-sets it.
            if (frame_end) begin
                r_flushFlag <= 1'b1;
            end else if (w_clearFlush) begin
                r_flushFlag <= 1'b0;
            end
        end
    end

    // Buffer write port; storage carries no reset, validity comes from level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= w_beatIn;
        end
    end

    // First-word-fall-through: the head beat is always on wdata.
    assign wdata = r_mem[r_rdPtr];

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + 1'b1;
            end else if (w_pop && !w_push) begin
                r_level <= r_level - 1'b1;
            end
        end
    end

`ifdef WR_PACKER_WATER_LEVEL_EN
    assign water_level = r_level;
`endif

    // Burst FSM state and the burst length / beat countdown registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_burstLen  <= '0;
            r_remaining <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_burstLen  <= w_burstLenNext;
            r_remaining <= w_remainingNext;
        end
    end

    // Next-state and outputs. A short flush burst is only requested once the
    // padded beat has landed, so it covers the whole frame tail. A flush burst
    // length is always below BURST_LEN, so the level fits in LEN_W bits.
    always_comb begin
        w_stateNext     = r_state;
        w_burstLenNext  = r_burstLen;
        w_remainingNext = r_remaining;
        w_clearFlush    = 1'b0;
        burst_req       = 1'b0;
        wvalid          = 1'b0;
        wlast           = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (r_level >= BURST_LEVEL) begin
                    w_stateNext    = ST_REQ;
                    w_burstLenNext = FULL_BURST;
                end else if (r_flushFlag && (r_level != '0) && !r_commitPending) begin
                    w_stateNext    = ST_REQ;
                    w_burstLenNext = LEN_W'(r_level);
                end else if (r_flushFlag && (r_level == '0) && (r_wordCnt == 3'd0)
                             && !r_commitPending) begin
                    w_clearFlush = 1'b1;
                end
            end

            ST_REQ: begin
                burst_req = 1'b1;
                if (burst_ack) begin
                    w_stateNext     = ST_DATA;
                    w_remainingNext = r_burstLen;
                end
            end

            ST_DATA: begin
                wvalid = 1'b1;
                wlast  = (r_remaining == LEN_ONE);
                if (wready) begin
                    w_remainingNext = r_remaining - LEN_ONE;
                    if (r_remaining == LEN_ONE) begin
                        w_stateNext = ST_IDLE;
                    end
                end
            end

            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign burst_len = r_burstLen;

endmodule

// File: tb/tb_video_wr_packer.sv
// ============================================================================
// tb_video_wr_packer
//
// Scoreboard bench for video_wr_packer. Stimulus tasks push the expected
// burst lengths and beats (built from the word stream) into queues; a monitor
// pops and compares on every burst handshake and beat handshake, and checks
// that burst_req/burst_len and wdata/wlast hold while stalled.
// ============================================================================
module tb_video_wr_packer;

    localparam int BDW = 5;
    localparam int BL  = 16;

    typedef struct {
        logic [255:0] data;
        logic         last;
    } beat_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [31:0]          in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic                 frame_end;
    logic                 burst_req;
    logic [$clog2(BL):0]  burst_len;
    logic                 burst_ack;
    logic [255:0]         wdata;
    logic                 wvalid;
    logic                 wready;
    logic                 wlast;
`ifdef WR_PACKER_WATER_LEVEL_EN
    logic [BDW:0]         water_level;
`endif

    beat_t                expBeats[$];
    logic [$clog2(BL):0]  expLens[$];
    int                   checks   = 0;
    int                   failures = 0;
    int                   popCount = 0;
    logic                 wrToggle = 1'b0;

    video_wr_packer #(
        .BUF_DEPTH_WIDTH(BDW),
        .BURST_LEN(BL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .frame_end(frame_end),
        .burst_req(burst_req),
        .burst_len(burst_len),
        .burst_ack(burst_ack),
        .wdata(wdata),
        .wvalid(wvalid),
        .wready(wready),
        .wlast(wlast)
`ifdef WR_PACKER_WATER_LEVEL_EN
        ,
        .water_level(water_level)
`endif
    );

    // Free-running clock
    always #5 clk = ~clk;

    // One comparison: counts it and reports a miss
    task automatic checkOutput(input string name, input logic [255:0] actual,
                               input logic [255:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Current buffered-beat count, from the port when it exists
    function automatic logic [BDW:0] levelNow();
`ifdef WR_PACKER_WATER_LEVEL_EN
        return water_level;
`else
        return dut.r_level;
`endif
    endfunction

    // Expected burst: nBeats beats starting at beat firstBeat of a stream of
    // totalWords words valued base+index; words past the stream end are zero.
    task automatic expectBurst(input logic [31:0] base, input int firstBeat,
                               input int nBeats, input int totalWords);
        expLens.push_back(($clog2(BL)+1)'(nBeats));
        for (int b = 0; b < nBeats; b++) begin
            beat_t e;
            e.data = '0;
            for (int k = 0; k < 8; k++) begin
                int idx;
                idx = (firstBeat + b) * 8 + k;
                if (idx < totalWords) e.data[k*32 +: 32] = base + 32'(idx);
            end
            e.last = (b == nBeats - 1);
            expBeats.push_back(e);
        end
    endtask

    // Offer n words base..base+n-1 back to back; frame_end optionally rides
    // with the last word.
    task automatic applyStimulus(input logic [31:0] base, input int n, input bit feOnLast);
        int  i     = 0;
        int  guard = 0;
        logic acc;
        while (i < n && guard < 4000) begin
            in_valid  = 1'b1;
            in_data   = base + 32'(i);
            frame_end = feOnLast && (i == n - 1);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            frame_end = 1'b0;
            if (acc) i++;
            guard++;
        end
        in_valid = 1'b0;
        checkOutput("wordsSent", 256'(i), 256'(n));
    endtask

    // Wait (bounded) for the scoreboard to empty, then idle to catch extras
    task automatic waitDrain(input int maxCycles);
        for (int c = 0; c < maxCycles; c++) begin
            if (expBeats.size() == 0 && expLens.size() == 0) break;
            @(posedge clk);
            #1;
        end
        checkOutput("drained", 256'(expBeats.size() + expLens.size()), 256'(0));
        repeat (30) @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        burst_ack = 1'b0;
        wrToggle  = 1'b0;
        expBeats.delete();
        expLens.delete();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // wready driver: constant high or toggling every cycle
    initial begin
        wready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (wrToggle) wready = ~wready;
            else          wready = 1'b1;
        end
    end

    // Monitor: scoreboard pops plus hold-while-stalled checks
    initial begin
        logic [255:0]         prevData;
        logic                 prevLast;
        logic                 prevStall;
        logic                 prevReqWait;
        logic [$clog2(BL):0]  prevLen;
        beat_t                e;
        prevStall   = 1'b0;
        prevReqWait = 1'b0;
        prevData    = '0;
        prevLast    = 1'b0;
        prevLen     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prevStall   = 1'b0;
                prevReqWait = 1'b0;
            end else begin
                if (prevStall) begin
                    checkOutput("wvalidHold", 256'(wvalid), 256'(1'b1));
                    checkOutput("wdataHold", wdata, prevData);
                    checkOutput("wlastHold", 256'(wlast), 256'(prevLast));
                end
                if (prevReqWait) begin
                    checkOutput("burstReqHold", 256'(burst_req), 256'(1'b1));
                    checkOutput("burstLenHold", 256'(burst_len), 256'(prevLen));
                end
                if (burst_req && burst_ack) begin
                    if (expLens.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpectedBurst: actual len=%0d required none", burst_len);
                    end else begin
                        checkOutput("burstLen", 256'(burst_len), 256'(expLens.pop_front()));
                    end
                end
                if (wvalid && wready) begin
                    popCount++;
                    if (expBeats.size() == 0) begin
                        checks++;
                        failures++;
                        $display("[TB] FAIL unexpectedBeat: actual=%0h required none", wdata);
                    end else begin
                        e = expBeats.pop_front();
                        checkOutput("beatData", wdata, e.data);
                        checkOutput("beatLast", 256'(wlast), 256'(e.last));
                    end
                end
                prevStall   = wvalid && !wready;
                prevData    = wdata;
                prevLast    = wlast;
                prevReqWait = burst_req && !burst_ack;
                prevLen     = burst_len;
            end
        end
    end

    // Watchdog
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed test sequence
    initial begin
        int   accCnt;
        int   popsSeen;
        int   accWithPops;
        bit   gotAcc;
        logic acc;
        int   startPops;

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        frame_end = 1'b0;
        burst_ack = 1'b0;
        #1;
        // Reset values while reset is held
        checkOutput("rstInReady", 256'(in_ready), 256'(1'b1));
        checkOutput("rstBurstReq", 256'(burst_req), 256'(1'b0));
        checkOutput("rstBurstLen", 256'(burst_len), 256'(0));
        checkOutput("rstWvalid", 256'(wvalid), 256'(1'b0));
        checkOutput("rstWlast", 256'(wlast), 256'(1'b0));
        checkOutput("rstLevel", 256'(levelNow()), 256'(0));
        doReset();

        // Full burst: 128 words -> one 16-beat burst
        $display("[TB] full burst");
        burst_ack = 1'b1;
        expectBurst(32'h0, 0, 16, 128);
        applyStimulus(32'h0, 128, 1'b0);
        waitDrain(200);
        checkOutput("fullLevelEmpty", 256'(levelNow()), 256'(0));
        doReset();

        // Flush: 20 words then a separate frame_end pulse
        $display("[TB] flush");
        burst_ack = 1'b1;
        expectBurst(32'h0, 0, 3, 20);
        applyStimulus(32'h0, 20, 1'b0);
        frame_end = 1'b1;
        @(posedge clk);
        #1;
        frame_end = 1'b0;
        checkOutput("flushCommitReadyLow", 256'(in_ready), 256'(1'b0));
        @(posedge clk);
        #1;
        checkOutput("flushReadyBack", 256'(in_ready), 256'(1'b1));
        waitDrain(200);
        checkOutput("flushFlagCleared", 256'(dut.r_flushFlag), 256'(1'b0));
        doReset();

        // Coincident end: frame_end with word 15 -> two beats, no padding
        $display("[TB] coincident end");
        burst_ack = 1'b1;
        expectBurst(32'h0, 0, 2, 16);
        applyStimulus(32'h0, 16, 1'b1);
        waitDrain(200);
        checkOutput("coincFlagCleared", 256'(dut.r_flushFlag), 256'(1'b0));
        checkOutput("coincLevelEmpty", 256'(levelNow()), 256'(0));
        doReset();

        // Buffer full: no ack, offer 300 words -> 263 accepted
        $display("[TB] buffer full");
        burst_ack = 1'b0;
        expectBurst(32'h0, 0, 16, 128);
        accCnt   = 0;
        in_valid = 1'b1;
        for (int c = 0; c < 330 && accCnt < 300; c++) begin
            in_data = 32'(accCnt);
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) accCnt++;
        end
        checkOutput("acceptedAtFull", 256'(accCnt), 256'(263));
        checkOutput("readyLowAtFull", 256'(in_ready), 256'(1'b0));
        checkOutput("fullLevel", 256'(levelNow()), 256'(32));
        burst_ack = 1'b1;
        @(posedge clk);
        #1;
        burst_ack   = 1'b0;
        popsSeen    = 0;
        accWithPops = -1;
        gotAcc      = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (in_ready) begin
                gotAcc      = 1'b1;
                accWithPops = popsSeen;
            end
            if (wvalid && wready) popsSeen++;
            @(posedge clk);
            #1;
            if (gotAcc) break;
        end
        in_valid = 1'b0;
        checkOutput("acceptResumed", 256'(gotAcc), 256'(1'b1));
        checkOutput("acceptAfterPop", 256'(accWithPops >= 1), 256'(1'b1));
        waitDrain(200);
        doReset();

        // wready toggling every cycle
        $display("[TB] wready stalls");
        burst_ack = 1'b1;
        wrToggle  = 1'b1;
        expectBurst(32'h5000_0000, 0, 16, 128);
        applyStimulus(32'h5000_0000, 128, 1'b0);
        waitDrain(300);
        doReset();

        // Reset mid-burst after 5 beats, then a fresh stream
        $display("[TB] reset mid-burst");
        burst_ack = 1'b1;
        expectBurst(32'hA000_0000, 0, 16, 128);
        startPops = popCount;
        applyStimulus(32'hA000_0000, 128, 1'b0);
        for (int c = 0; c < 200; c++) begin
            if (popCount - startPops >= 5) break;
            @(posedge clk);
            #1;
        end
        checkOutput("midBurstPops", 256'(popCount - startPops), 256'(5));
        expBeats.delete();
        expLens.delete();
        rst = 1'b1;
        #1;
        checkOutput("midRstWvalid", 256'(wvalid), 256'(1'b0));
        checkOutput("midRstBurstReq", 256'(burst_req), 256'(1'b0));
        checkOutput("midRstWlast", 256'(wlast), 256'(1'b0));
        checkOutput("midRstLevel", 256'(levelNow()), 256'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expectBurst(32'hB000_0000, 0, 16, 128);
        applyStimulus(32'hB000_0000, 128, 1'b0);
        waitDrain(200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
